// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset PC, NOP, fetch FSM encoding,
// and the IF/ID and redirect bundles exchanged between fetch sub-blocks.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  // Fetch FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  // One fetched instruction plus its PC+4; used for IF/ID and the skid slot
  typedef struct packed {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  // Control-path redirect request as seen by fetch
  typedef struct packed {
    logic        redirect;
    logic [31:0] target;
  } redir_t;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect target computation: beq target, j target, branch-over-jump priority.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic        br_taken,
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [31:0] jmp_pc4,
  input  logic [25:0] jmp_idx,
  output redir_t      redir
);

  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;

  // Word offset sign-extended and scaled to bytes; wraps modulo 2^32
  assign br_tgt  = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
  assign jmp_tgt = {jmp_pc4[31:28], jmp_idx, 2'b00};

  // The branch is the older instruction, so it wins over a same-cycle jump
  always_comb begin
    redir.redirect = br_taken | jmp;
    redir.target   = br_taken ? br_tgt : jmp_tgt;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem read, IF/ID register,
// one-entry skid for decode stalls, and flush/redirect handling.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [31:0] jmp_pc4,
  input  logic [25:0] jmp_idx,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend_tgt, pend_nxt;
  ifid_t       ifid, ifid_nxt;
  ifid_t       skid, skid_nxt;
  redir_t      redir;
  logic        ack;
  logic        loadable;
  logic [31:0] pc_inc;

  next_pc_calc u_npc (
    .br_taken (br_taken),
    .br_pc4   (br_pc4),
    .br_imm   (br_imm),
    .jmp      (jmp),
    .jmp_pc4  (jmp_pc4),
    .jmp_idx  (jmp_idx),
    .redir    (redir)
  );

  // Request is a pure function of state; address is the PC, stable until ack
  assign imem_req  = (state == ST_FETCH) || (state == ST_DROP);
  assign imem_addr = pc;

  // A response only counts while a request is actually outstanding
  assign ack      = imem_ack & imem_req;
  assign loadable = !ifid.vld || !id_stall;
  assign pc_inc   = pc + PC_INC;

  assign if_id_valid = ifid.vld;
  assign if_id_instr = ifid.instr;
  assign if_id_pc4   = ifid.pc4;

  // Next-state logic for FSM, PC, pending target, IF/ID and skid
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_tgt;
    ifid_nxt  = ifid;
    skid_nxt  = skid;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (redir.redirect) begin
          ifid_nxt.vld = 1'b0;
          skid_nxt.vld = 1'b0;
          if (ack) begin
            pc_nxt = redir.target;
          end else begin
            // Request already on the bus must finish before re-issuing
            pend_nxt  = redir.target;
            state_nxt = ST_DROP;
          end
        end else if (ack) begin
          pc_nxt = pc_inc;
          if (loadable) begin
            ifid_nxt = '{vld: 1'b1, instr: imem_rdata, pc4: pc_inc};
          end else begin
            skid_nxt  = '{vld: 1'b1, instr: imem_rdata, pc4: pc_inc};
            state_nxt = ST_HOLD;
          end
        end else if (loadable) begin
          ifid_nxt.vld = 1'b0;
        end
      end
      ST_HOLD: begin
        if (redir.redirect) begin
          ifid_nxt.vld = 1'b0;
          skid_nxt.vld = 1'b0;
          pc_nxt       = redir.target;
          state_nxt    = ST_FETCH;
        end else if (!id_stall) begin
          ifid_nxt     = skid;
          skid_nxt.vld = 1'b0;
          state_nxt    = ST_FETCH;
        end
      end
      ST_DROP: begin
        ifid_nxt.vld = 1'b0;
        skid_nxt.vld = 1'b0;
        if (redir.redirect) pend_nxt = redir.target;
        if (ack) begin
          // Stale word is dropped; the newest redirect target is the one to use
          pc_nxt    = redir.redirect ? redir.target : pend_tgt;
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      pend_tgt <= '0;
      ifid     <= '{vld: 1'b0, instr: NOP_INSTR, pc4: 32'h0};
      skid     <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_tgt <= pend_nxt;
      ifid     <= ifid_nxt;
      skid     <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against an instruction-stream model (sequential PCs, restarted at
// each redirect target).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        br_taken;
  logic [31:0] br_pc4;
  logic [15:0] br_imm;
  logic        jmp;
  logic [31:0] jmp_pc4;
  logic [25:0] jmp_idx;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;

  int total = 0;
  int bad   = 0;

  // Memory model controls: fixed latency (>=0) or random 0..2 (<0)
  int mem_lat     = 0;
  bit spurious_en = 0;
  bit busy        = 0;
  int cnt         = 0;
  logic [31:0] req_addr;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall),
    .br_taken(br_taken), .br_pc4(br_pc4), .br_imm(br_imm),
    .jmp(jmp), .jmp_pc4(jmp_pc4), .jmp_idx(jmp_idx),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Instruction memory: answers each request after its latency, checks the
  // address stays put while waiting, and optionally injects unsolicited acks
  always @(negedge clk) begin
    if (!imem_req) begin
      busy       = 0;
      imem_ack   = spurious_en && ($urandom % 8 == 0);
      imem_rdata = $urandom;
    end else begin
      if (!busy) begin
        busy     = 1;
        req_addr = imem_addr;
        cnt      = (mem_lat < 0) ? int'($urandom % 3) : mem_lat;
        total++;
        if (imem_addr[1:0] !== 2'b00) begin
          bad++; $display("FAIL addr_align got=%h", imem_addr);
        end
      end else begin
        total++;
        if (imem_addr !== req_addr) begin
          bad++; $display("FAIL addr_stable got=%h exp=%h", imem_addr, req_addr);
        end
      end
      if (cnt == 0) begin
        imem_ack   = 1;
        imem_rdata = word_at(imem_addr);
        busy       = 0;
      end else begin
        imem_ack = 0;
        cnt--;
      end
    end
  end

  task automatic clear_ctl;
    id_stall = 0; br_taken = 0; jmp = 0;
    br_pc4 = 0; br_imm = 0; jmp_pc4 = 0; jmp_idx = 0;
  endtask

  task automatic pulse_reset;
    rst_n = 0;
    clear_ctl();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear_ctl();
    repeat (2) @(negedge clk);
    total += 5;
    if (imem_req !== 1'b0)       begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    if (imem_addr !== 32'h0)     begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    if (if_id_valid !== 1'b0)    begin bad++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
    if (if_id_instr !== 32'h0)   begin bad++; $display("FAIL rst_instr got=%h exp=0", if_id_instr); end
    if (if_id_pc4 !== 32'h0)     begin bad++; $display("FAIL rst_pc4 got=%h exp=0", if_id_pc4); end
    rst_n = 1;
  endtask

  // Zero-wait memory, no stalls: one instruction per cycle
  task automatic test_sequential;
    @(negedge clk);
    total += 3;
    if (imem_req !== 1'b1)     begin bad++; $display("FAIL seq_req0 got=%b exp=1", imem_req); end
    if (imem_addr !== 32'h0)   begin bad++; $display("FAIL seq_addr0 got=%h exp=0", imem_addr); end
    if (if_id_valid !== 1'b0)  begin bad++; $display("FAIL seq_valid0 got=%b exp=0", if_id_valid); end
    @(negedge clk);
    total += 4;
    if (imem_addr !== 32'h4)           begin bad++; $display("FAIL seq_addr1 got=%h exp=4", imem_addr); end
    if (if_id_valid !== 1'b1)          begin bad++; $display("FAIL seq_valid1 got=%b exp=1", if_id_valid); end
    if (if_id_instr !== 32'hA5A5_0000) begin bad++; $display("FAIL seq_instr1 got=%h exp=a5a50000", if_id_instr); end
    if (if_id_pc4 !== 32'h4)           begin bad++; $display("FAIL seq_pc4_1 got=%h exp=4", if_id_pc4); end
    @(negedge clk);
    total += 3;
    if (imem_addr !== 32'h8)           begin bad++; $display("FAIL seq_addr2 got=%h exp=8", imem_addr); end
    if (if_id_instr !== 32'hA5A5_0004) begin bad++; $display("FAIL seq_instr2 got=%h exp=a5a50004", if_id_instr); end
    if (if_id_pc4 !== 32'h8)           begin bad++; $display("FAIL seq_pc4_2 got=%h exp=8", if_id_pc4); end
  endtask

  // Backward branch while the word for 0x8 is acked in the same cycle
  task automatic test_branch;
    br_taken = 1; br_pc4 = 32'h20; br_imm = 16'hFFFC;
    @(negedge clk);
    br_taken = 0;
    total += 2;
    if (imem_addr !== 32'h10) begin bad++; $display("FAIL br_addr got=%h exp=10", imem_addr); end
    if (if_id_valid !== 1'b0) begin bad++; $display("FAIL br_flush got=%b exp=0", if_id_valid); end
    @(negedge clk);
    total += 2;
    if (if_id_valid !== 1'b1 || if_id_instr !== word_at(32'h10))
      begin bad++; $display("FAIL br_first got=%b/%h exp=1/%h", if_id_valid, if_id_instr, word_at(32'h10)); end
    if (if_id_pc4 !== 32'h14) begin bad++; $display("FAIL br_pc4 got=%h exp=14", if_id_pc4); end
  endtask

  // Branch and jump together: branch wins; then jump alone
  task automatic test_jmp_prio;
    br_taken = 1; br_pc4 = 32'h40; br_imm = 16'h0001;
    jmp = 1; jmp_pc4 = 32'h9000_0004; jmp_idx = 26'h0000100;
    @(negedge clk);
    br_taken = 0;
    total += 2;
    if (imem_addr !== 32'h44) begin bad++; $display("FAIL prio_addr got=%h exp=44", imem_addr); end
    if (if_id_valid !== 1'b0) begin bad++; $display("FAIL prio_flush got=%b exp=0", if_id_valid); end
    @(negedge clk);
    jmp = 0;
    total += 1;
    if (imem_addr !== 32'h9000_0400) begin bad++; $display("FAIL jmp_addr got=%h exp=90000400", imem_addr); end
  endtask

  // Decode stall when the ack for 0x8 lands: word parks in the skid slot
  task automatic test_stall;
    pulse_reset();
    repeat (3) @(negedge clk);
    id_stall = 1;
    @(negedge clk);
    total += 3;
    if (imem_req !== 1'b0)             begin bad++; $display("FAIL stall_req got=%b exp=0", imem_req); end
    if (if_id_valid !== 1'b1)          begin bad++; $display("FAIL stall_valid got=%b exp=1", if_id_valid); end
    if (if_id_instr !== 32'hA5A5_0004) begin bad++; $display("FAIL stall_instr got=%h exp=a5a50004", if_id_instr); end
    @(negedge clk);
    total += 2;
    if (imem_req !== 1'b0)             begin bad++; $display("FAIL stall_req2 got=%b exp=0", imem_req); end
    if (if_id_instr !== 32'hA5A5_0004) begin bad++; $display("FAIL stall_instr2 got=%h exp=a5a50004", if_id_instr); end
    id_stall = 0;
    @(negedge clk);
    total += 4;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA5A5_0008)
      begin bad++; $display("FAIL unstall_instr got=%b/%h exp=1/a5a50008", if_id_valid, if_id_instr); end
    if (if_id_pc4 !== 32'hC)  begin bad++; $display("FAIL unstall_pc4 got=%h exp=c", if_id_pc4); end
    if (imem_req !== 1'b1)    begin bad++; $display("FAIL unstall_req got=%b exp=1", imem_req); end
    if (imem_addr !== 32'hC)  begin bad++; $display("FAIL unstall_addr got=%h exp=c", imem_addr); end
  endtask

  // Two-cycle memory, jump in the request's first cycle: stale word dropped
  task automatic test_drop;
    bit seen;
    mem_lat = 1;
    pulse_reset();
    @(negedge clk);
    jmp = 1; jmp_pc4 = 32'h9000_0004; jmp_idx = 26'h0000100;
    @(negedge clk);
    jmp = 0;
    total += 3;
    if (imem_req !== 1'b1)    begin bad++; $display("FAIL drop_req got=%b exp=1", imem_req); end
    if (imem_addr !== 32'h0)  begin bad++; $display("FAIL drop_stale_addr got=%h exp=0", imem_addr); end
    if (if_id_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b exp=0", if_id_valid); end
    @(negedge clk);
    total += 1;
    if (imem_addr !== 32'h9000_0400) begin bad++; $display("FAIL drop_tgt got=%h exp=90000400", imem_addr); end
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (if_id_valid) begin
        seen = 1;
        total++;
        if (if_id_instr !== word_at(32'h9000_0400))
          begin bad++; $display("FAIL drop_first got=%h exp=%h", if_id_instr, word_at(32'h9000_0400)); end
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL drop_timeout got=no valid exp=valid within 6 cycles"); end
    mem_lat = 0;
  endtask

  // Reset asserted between edges must clear outputs immediately
  task automatic test_async_reset;
    pulse_reset();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    total += 5;
    if (imem_req !== 1'b0)     begin bad++; $display("FAIL arst_req got=%b exp=0", imem_req); end
    if (imem_addr !== 32'h0)   begin bad++; $display("FAIL arst_addr got=%h exp=0", imem_addr); end
    if (if_id_valid !== 1'b0)  begin bad++; $display("FAIL arst_valid got=%b exp=0", if_id_valid); end
    if (if_id_instr !== 32'h0) begin bad++; $display("FAIL arst_instr got=%h exp=0", if_id_instr); end
    if (if_id_pc4 !== 32'h0)   begin bad++; $display("FAIL arst_pc4 got=%h exp=0", if_id_pc4); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total += 2;
    if (imem_req !== 1'b1)   begin bad++; $display("FAIL arst_rel_req got=%b exp=1", imem_req); end
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL arst_rel_addr got=%h exp=0", imem_addr); end
  endtask

  // Random latency, stalls, redirects and stray acks; decode must see the
  // program stream: consecutive words, restarting at each redirect target
  task automatic test_random;
    logic [31:0] exp_pc;
    int consumed;
    mem_lat = -1;
    spurious_en = 1;
    pulse_reset();
    repeat (2) @(negedge clk);
    exp_pc = 32'h0;
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      id_stall = ($urandom % 4 == 0);
      br_taken = ($urandom % 24 == 0);
      br_pc4   = $urandom & 32'hFFFF_FFFC;
      br_imm   = 16'($urandom);
      jmp      = ($urandom % 24 == 0);
      jmp_pc4  = $urandom & 32'hFFFF_FFFC;
      jmp_idx  = 26'($urandom);
      if (if_id_valid && !id_stall) begin
        total++;
        consumed++;
        if (if_id_instr !== word_at(exp_pc) || if_id_pc4 !== exp_pc + 32'd4) begin
          bad++;
          $display("FAIL rand_stream got=%h/%h exp=%h/%h", if_id_instr, if_id_pc4, word_at(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (br_taken)  exp_pc = br_pc4 + 32'($signed(br_imm) * 4);
      else if (jmp)  exp_pc = (jmp_pc4 & 32'hF000_0000) | (32'(jmp_idx) << 2);
    end
    clear_ctl();
    spurious_en = 0;
    mem_lat = 0;
    total++;
    if (consumed < 300) begin bad++; $display("FAIL rand_progress got=%0d exp>=300", consumed); end
  endtask

  initial begin
    rst_n = 0;
    imem_ack = 0;
    imem_rdata = 0;
    clear_ctl();
    test_reset();
    test_sequential();
    test_branch();
    test_jmp_prio();
    test_stall();
    test_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage for the pipelined MIPS core: the producer of the 32-bit instruction word that the decode-stage controller consumes.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Fills the IF/ID pipeline register and applies branch/jump redirects returned by the control path.
- Includes a one-entry skid buffer so a decode stall never loses a returned instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  word-aligned read address (bits[1:0]=0)
- imem_ack  input  1  read complete; imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- id_stall  input  1  decode cannot accept a new instruction this cycle
- br_taken  input  1  taken conditional branch (beq resolved)
- br_pc4  input  32  PC+4 of the branch instruction
- br_imm  input  16  branch immediate (word offset)
- jmp  input  1  unconditional jump (j)
- jmp_pc4  input  32  PC+4 of the jump instruction
- jmp_idx  input  26  jump index field
- if_id_valid  output  1  IF/ID register holds a live instruction
- if_id_instr  output  32  instruction to the decode controller
- if_id_pc4  output  32  PC+4 of if_id_instr

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc4=0, skid empty, pending target=0.
- States: IDLE, FETCH, HOLD, DROP.
- IDLE: entered only from reset. Go to FETCH on the first clock edge after rst_n deasserts.
- Memory protocol:
  - imem_req=1 exactly in FETCH and DROP.
  - imem_addr=pc, held stable until ack.
  - Ack is allowed in the same cycle req first rises (zero-wait).
  - Exactly one request outstanding at a time.
  - imem_ack outside FETCH/DROP is ignored.
- Consume rule: decode takes the IF/ID entry when if_id_valid && !id_stall.
- IF/ID is loadable when !if_id_valid || !id_stall. When loadable and no new word is available, the next if_id_valid=0 (bubble).
- Redirect target:
  - Branch target = br_pc4 + ({{14{br_imm[15]}}, br_imm, 2'b00}), modulo 2^32.
  - Jump target = {jmp_pc4[31:28], jmp_idx, 2'b00}.
  - br_taken && jmp in the same cycle: branch wins, because it is the older instruction.
- Redirect effects, all taking effect on the next edge:
  - if_id_valid<=0 regardless of id_stall; the skid buffer is cleared.
  - FETCH with ack this cycle: rdata discarded; pc<=target; stay in FETCH.
  - FETCH without ack: latch target into the pending register; go to DROP.
  - HOLD: pc<=target; go to FETCH.
  - DROP: a newer redirect overwrites the pending target.
- FETCH, ack, no redirect:
  - pc<=pc+4, wrapping modulo 2^32.
  - If IF/ID is loadable: IF/ID<={1, rdata, pc+4}; stay in FETCH, so req stays high with the new address next cycle.
  - Else: skid<={rdata, pc+4}; go to HOLD.
- FETCH, no ack, no redirect: stay in FETCH with address unchanged.
- HOLD:
  - imem_req=0.
  - When !id_stall: IF/ID<=skid; go to FETCH.
  - Else: hold.
- DROP:
  - Waits for the ack of the stale request.
  - On ack: discard rdata; pc<=pending target; go to FETCH.
  - IF/ID remains invalid throughout.
- Throughput: one instruction per cycle with zero-wait memory and no stalls. Redirect penalty: the IF/ID register is flushed.
- Reset mid-operation: all state returns to reset values immediately. A memory response for the abandoned request is ignored; it arrives while imem_req=0 or in IDLE.

Decomposition:
- Shared package (mips_pkg): RESET_PC default, NOP_INSTR=32'h0000_0000, fetch state encoding, PC_INC=4.
- Sub-module next_pc_calc (combinational): computes the branch and jump targets, applies branch-over-jump priority, and outputs {redirect, target}.

Test Plan:
- Reset then zero-wait ack every cycle, rdata=addr^32'hA5A5_0000:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - if_id_instr sequence 0xA5A5_0000, 0xA5A5_0004, with if_id_pc4 0x4, 0x8, one cycle after each ack.
- br_taken with br_pc4=0x20 and br_imm=16'hFFFC:
  - Next imem_addr=0x10.
  - if_id_valid=0 for one cycle.
  - The concurrently acked word is discarded.
- jmp with jmp_pc4=0x9000_0004 and jmp_idx=26'h0000100, plus br_taken=1 in the same cycle with br_pc4=0x40, imm=1:
  - The branch wins; next address=0x44.
  - Repeat with br_taken=0: next address=0x9000_0400.
- id_stall high with if_id_valid=1 when the ack for 0x8 arrives:
  - State goes to HOLD and imem_req=0.
  - if_id_instr is unchanged while stalled.
  - After id_stall falls, IF/ID loads the word from 0x8 and a fetch of 0xC follows.
- Two-cycle-latency memory, jmp asserted in the request's first cycle:
  - State goes to DROP.
  - The stale ack data never appears with if_id_valid=1.
  - The next request is at the jump target.
- rst_n pulsed low mid-FETCH:
  - Outputs return to reset values asynchronously, before the next edge.
  - After release, the first imem_addr=RESET_PC.
